// File: rtl/risc_pkg.sv
// Shared definitions for the 16-bit RISC core: address and instruction
// widths, opcode field position, the HALT opcode and the fetch FSM states.
// IF_HALT_DETECT_EN adds the HALTED fetch state.
package risc_pkg;
  localparam int PC_W_DEF = 16;
  localparam int INST_W   = 16;
  localparam int OPC_MSB  = 15;
  localparam int OPC_LSB  = 11;
  localparam logic [OPC_MSB-OPC_LSB:0] OPC_HALT = 5'b11111;

  typedef enum logic [1:0] {
    FS_IDLE,
    FS_REQ,
    FS_HOLD
`ifdef IF_HALT_DETECT_EN
    , FS_HALTED
`endif
  } fetch_state_e;

  function automatic logic is_halt(input logic [INST_W-1:0] inst);
    return inst[OPC_MSB:OPC_LSB] == OPC_HALT;
  endfunction
endpackage

// File: rtl/pc_unit.sv
// Program counter register.
//   clk_i, rst_i : clock, synchronous active-high reset (loads RESET_PC)
//   ld_i/ld_val_i: load a redirect target (wins over increment)
//   inc_i        : advance by one, wrapping modulo 2^PC_W
//   pc_o         : current PC
//   pc_nxt_o     : value the PC takes at the next edge
module pc_unit #(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            ld_i,
  input  logic [PC_W-1:0] ld_val_i,
  input  logic            inc_i,
  output logic [PC_W-1:0] pc_o,
  output logic [PC_W-1:0] pc_nxt_o
);
  logic [PC_W-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (ld_i)       pc_d = ld_val_i;
    else if (inc_i) pc_d = pc_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) pc_q <= RESET_PC;
    else       pc_q <= pc_d;
  end

  assign pc_o     = pc_q;
  assign pc_nxt_o = pc_d;
endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage. Issues word reads to instruction memory over a
// req/ack handshake and hands each instruction with its PC to the decoder
// over valid/ready. Branch redirects squash any fetch in flight.
// Ports:
//   I_CLK, I_RST        clock, synchronous active-high reset
//   I_EN                allow new requests
//   I_BR_TAKEN/TARGET   redirect strobe and address
//   O_MEM_REQ/ADDR      memory read request, held until I_MEM_ACK
//   I_MEM_ACK/DATA      memory response
//   O_INST/_PC/_VALID   instruction to decoder, I_INST_READY accepts
//   O_HALTED            fetch stopped on HALT
// Macro IF_HALT_DETECT_EN: stop fetching after a HALT instruction is taken
// by the decoder; without it O_HALTED is tied low.
module inst_fetch
  import risc_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              I_CLK,
  input  logic              I_RST,
  input  logic              I_EN,
  input  logic              I_BR_TAKEN,
  input  logic [PC_W-1:0]   I_BR_TARGET,
  output logic              O_MEM_REQ,
  output logic [PC_W-1:0]   O_MEM_ADDR,
  input  logic              I_MEM_ACK,
  input  logic [INST_W-1:0] I_MEM_DATA,
  output logic [INST_W-1:0] O_INST,
  output logic [PC_W-1:0]   O_INST_PC,
  output logic              O_INST_VALID,
  input  logic              I_INST_READY,
  output logic              O_HALTED
);
  fetch_state_e      state_q, state_d;
  logic              squash_q, squash_d;
  logic              req_q, req_d;
  logic              vld_q, vld_d;
  logic [PC_W-1:0]   addr_q, addr_d;
  logic [PC_W-1:0]   inst_pc_q, inst_pc_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [PC_W-1:0]   pc, pc_nxt;
  logic              xfer, keep;

  assign xfer = vld_q & I_INST_READY;
  // Response is kept only if nothing redirected the fetch it belongs to.
  assign keep = (state_q == FS_REQ) & I_MEM_ACK & ~squash_q & ~I_BR_TAKEN;

  pc_unit #(.PC_W(PC_W), .RESET_PC(RESET_PC)) u_pc (
    .clk_i    (I_CLK),
    .rst_i    (I_RST),
    .ld_i     (I_BR_TAKEN),
    .ld_val_i (I_BR_TARGET),
    .inc_i    (keep),
    .pc_o     (pc),
    .pc_nxt_o (pc_nxt)
  );

  // State register and registered outputs
  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      state_q   <= FS_IDLE;
      squash_q  <= 1'b0;
      req_q     <= 1'b0;
      vld_q     <= 1'b0;
      addr_q    <= RESET_PC;
      inst_pc_q <= RESET_PC;
      inst_q    <= '0;
    end else begin
      state_q   <= state_d;
      squash_q  <= squash_d;
      req_q     <= req_d;
      vld_q     <= vld_d;
      addr_q    <= addr_d;
      inst_pc_q <= inst_pc_d;
      inst_q    <= inst_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    squash_d = squash_q;
    case (state_q)
      FS_IDLE: if (!I_BR_TAKEN && I_EN) state_d = FS_REQ;
      FS_REQ: begin
        if (I_MEM_ACK) begin
          squash_d = 1'b0;
          if (I_BR_TAKEN)    state_d = FS_REQ;
          else if (squash_q) state_d = I_EN ? FS_REQ : FS_IDLE;
          else               state_d = FS_HOLD;
        end else if (I_BR_TAKEN) begin
          // request must stay up until acked; remember to drop its data
          squash_d = 1'b1;
        end
      end
      FS_HOLD: begin
        if (I_BR_TAKEN) state_d = FS_REQ;
        else if (xfer) begin
`ifdef IF_HALT_DETECT_EN
          if (is_halt(inst_q)) state_d = FS_HALTED;
          else
`endif
          state_d = I_EN ? FS_REQ : FS_IDLE;
        end
      end
`ifdef IF_HALT_DETECT_EN
      FS_HALTED: if (I_BR_TAKEN) state_d = FS_REQ;
`endif
      default: state_d = FS_IDLE;
    endcase
  end

  // Output next values
  always_comb begin
    req_d     = (state_d == FS_REQ);
    vld_d     = (state_d == FS_HOLD);
    inst_d    = keep ? I_MEM_DATA : inst_q;
    inst_pc_d = keep ? addr_q : inst_pc_q;
    // Address freezes while a request is outstanding, else tracks the PC.
    addr_d    = (state_q == FS_REQ && !I_MEM_ACK) ? addr_q : pc_nxt;
  end

`ifdef IF_HALT_DETECT_EN
  logic halted_q;
  always_ff @(posedge I_CLK) begin
    if (I_RST) halted_q <= 1'b0;
    else       halted_q <= (state_d == FS_HALTED);
  end
  assign O_HALTED = halted_q;
`else
  assign O_HALTED = 1'b0;
`endif

  assign O_MEM_REQ    = req_q;
  assign O_MEM_ADDR   = addr_q;
  assign O_INST       = inst_q;
  assign O_INST_PC    = inst_pc_q;
  assign O_INST_VALID = vld_q;

  logic unused;
  assign unused = ^pc;
endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;
  logic        I_CLK = 1'b0;
  logic        I_RST = 1'b1;
  logic        I_EN = 1'b0;
  logic        I_BR_TAKEN = 1'b0;
  logic [15:0] I_BR_TARGET = '0;
  logic        O_MEM_REQ;
  logic [15:0] O_MEM_ADDR;
  logic        I_MEM_ACK = 1'b0;
  logic [15:0] I_MEM_DATA = '0;
  logic [15:0] O_INST;
  logic [15:0] O_INST_PC;
  logic        O_INST_VALID;
  logic        I_INST_READY = 1'b1;
  logic        O_HALTED;

  int npass = 0, nchk = 0;
  int ack_dly = 0, wait_cnt = 0;
  logic ack_force = 1'b0;

  inst_fetch dut (
    .I_CLK(I_CLK), .I_RST(I_RST), .I_EN(I_EN),
    .I_BR_TAKEN(I_BR_TAKEN), .I_BR_TARGET(I_BR_TARGET),
    .O_MEM_REQ(O_MEM_REQ), .O_MEM_ADDR(O_MEM_ADDR),
    .I_MEM_ACK(I_MEM_ACK), .I_MEM_DATA(I_MEM_DATA),
    .O_INST(O_INST), .O_INST_PC(O_INST_PC), .O_INST_VALID(O_INST_VALID),
    .I_INST_READY(I_INST_READY), .O_HALTED(O_HALTED)
  );

  always #5 I_CLK = ~I_CLK;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return (a == 16'd3) ? 16'hF800 : (a ^ 16'h5A00);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    if (obs === exp) npass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Advance one cycle and answer the memory request after ack_dly cycles.
  task automatic tick();
    @(posedge I_CLK); #1;
    if (O_MEM_REQ) begin
      if (wait_cnt >= ack_dly) begin
        I_MEM_ACK = 1'b1; I_MEM_DATA = mem_word(O_MEM_ADDR); wait_cnt = 0;
      end else begin
        I_MEM_ACK = 1'b0; wait_cnt++;
      end
    end else begin
      I_MEM_ACK = ack_force; I_MEM_DATA = 16'hDEAD; wait_cnt = 0;
    end
  endtask

  initial begin
    // reset
    tick(); tick();
    chk("rst_req", O_MEM_REQ, 0);
    chk("rst_addr", O_MEM_ADDR, 0);
    chk("rst_vld", O_INST_VALID, 0);
    chk("rst_inst", O_INST, 0);
    chk("rst_ipc", O_INST_PC, 0);
    chk("rst_halt", O_HALTED, 0);

    // zero-wait streaming 0,1,2
    I_RST = 1'b0; I_EN = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("s_req", O_MEM_REQ, 1);
      chk("s_addr", O_MEM_ADDR, k);
      chk("s_vld0", O_INST_VALID, 0);
      tick();
      chk("s_vld", O_INST_VALID, 1);
      chk("s_ipc", O_INST_PC, k);
      chk("s_inst", O_INST, mem_word(16'(k)));
      chk("s_noreq", O_MEM_REQ, 0);
    end

    // ack delayed 3 cycles at addr 3
    ack_dly = 3;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("d_req", O_MEM_REQ, 1);
      chk("d_addr", O_MEM_ADDR, 3);
      chk("d_vld0", O_INST_VALID, 0);
    end
    tick();
    chk("d_vld", O_INST_VALID, 1);
    chk("d_ipc", O_INST_PC, 3);
    chk("d_inst", O_INST, 16'hF800);

    // decoder stalls 5 cycles
    I_INST_READY = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("st_vld", O_INST_VALID, 1);
      chk("st_inst", O_INST, 16'hF800);
      chk("st_noreq", O_MEM_REQ, 0);
    end
    I_INST_READY = 1'b1;
    tick();
`ifdef IF_HALT_DETECT_EN
    chk("h_halt", O_HALTED, 1);
    chk("h_vld", O_INST_VALID, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("h_noreq", O_MEM_REQ, 0);
      chk("h_halt2", O_HALTED, 1);
    end
    I_BR_TAKEN = 1'b1; I_BR_TARGET = 16'h0010;
    tick();
    I_BR_TAKEN = 1'b0;
    chk("h_unhalt", O_HALTED, 0);
    chk("h_req", O_MEM_REQ, 1);
    chk("h_addr", O_MEM_ADDR, 16'h0010);
`else
    chk("r_req", O_MEM_REQ, 1);
    chk("r_addr", O_MEM_ADDR, 4);
    chk("r_nohalt", O_HALTED, 0);
`endif

    // redirect to 5 while the current request is outstanding
    I_BR_TAKEN = 1'b1; I_BR_TARGET = 16'h0005;
    for (int i = 0; i < 3; i++) begin
      tick();
      I_BR_TAKEN = 1'b0;
      chk("q1_req", O_MEM_REQ, 1);
      chk("q1_vld", O_INST_VALID, 0);
    end
    tick();
    chk("q1_req5", O_MEM_REQ, 1);
    chk("q1_addr5", O_MEM_ADDR, 16'h0005);
    chk("q1_vld5", O_INST_VALID, 0);

    // redirect to 0x40 while request to 5 pending
    I_BR_TAKEN = 1'b1; I_BR_TARGET = 16'h0040;
    for (int i = 0; i < 3; i++) begin
      tick();
      I_BR_TAKEN = 1'b0;
      chk("q2_addr", O_MEM_ADDR, 16'h0005);
      chk("q2_vld", O_INST_VALID, 0);
    end
    tick();
    chk("q2_req40", O_MEM_REQ, 1);
    chk("q2_addr40", O_MEM_ADDR, 16'h0040);
    chk("q2_vld40", O_INST_VALID, 0);

    // branch in the same cycle as the ack: data dropped, refetch at 0xFFFF
    ack_dly = 0;
    tick();
    chk("b_ack_addr", O_MEM_ADDR, 16'h0040);
    I_BR_TAKEN = 1'b1; I_BR_TARGET = 16'hFFFF;
    tick();
    I_BR_TAKEN = 1'b0;
    chk("b_vld", O_INST_VALID, 0);
    chk("b_req", O_MEM_REQ, 1);
    chk("b_addr", O_MEM_ADDR, 16'hFFFF);
    tick();
    chk("w_vld", O_INST_VALID, 1);
    chk("w_ipc", O_INST_PC, 16'hFFFF);
    chk("w_inst", O_INST, 16'hA5FF);
    tick();
    chk("w_req", O_MEM_REQ, 1);
    chk("w_wrap", O_MEM_ADDR, 16'h0000);

    // branch while holding: held instruction dropped though READY high
    tick();
    chk("hb_vld", O_INST_VALID, 1);
    chk("hb_ipc", O_INST_PC, 0);
    I_BR_TAKEN = 1'b1; I_BR_TARGET = 16'h0020;
    tick();
    I_BR_TAKEN = 1'b0;
    chk("hb_drop", O_INST_VALID, 0);
    chk("hb_addr", O_MEM_ADDR, 16'h0020);

    // enable low: current fetch completes, then idle
    I_EN = 1'b0;
    tick();
    chk("e_vld", O_INST_VALID, 1);
    chk("e_ipc", O_INST_PC, 16'h0020);
    tick();
    chk("e_idle", O_MEM_REQ, 0);
    ack_force = 1'b1;
    tick();
    tick();
    chk("e_idle2", O_MEM_REQ, 0);
    chk("e_ackign", O_INST_VALID, 0);
    ack_force = 1'b0;

    // branch in idle, then enable
    I_BR_TAKEN = 1'b1; I_BR_TARGET = 16'h0030;
    tick();
    I_BR_TAKEN = 1'b0;
    chk("i_noreq", O_MEM_REQ, 0);
    I_EN = 1'b1;
    tick();
    chk("i_req", O_MEM_REQ, 1);
    chk("i_addr", O_MEM_ADDR, 16'h0030);

    // reset mid-request, late ack ignored
    I_MEM_ACK = 1'b0; ack_dly = 5; I_RST = 1'b1;
    tick();
    chk("mr_req", O_MEM_REQ, 0);
    chk("mr_addr", O_MEM_ADDR, 0);
    I_RST = 1'b0; I_EN = 1'b0; ack_force = 1'b1;
    tick();
    tick();
    chk("mr_vld", O_INST_VALID, 0);
    chk("mr_req2", O_MEM_REQ, 0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage of the 16-bit RISC processor, directly upstream of the instruction decoder. Holds the program counter, issues word reads to instruction memory over a req/ack handshake, and presents each fetched 16-bit instruction with its PC to the decoder under a valid/ready handshake. Handles branch redirects and squashes any fetch already in flight.

## Interface
- PC_W, 16, program-counter and memory-address width (word addressed)
- RESET_PC, 0, PC value loaded on reset
- I_CLK  in  1  clock; all state updates on rising edge
- I_RST  in  1  reset, synchronous, active-high
- I_EN  in  1  fetch enable from control unit; new requests start only when high
- I_BR_TAKEN  in  1  redirect strobe, one cycle
- I_BR_TARGET  in  PC_W  redirect address, valid with I_BR_TAKEN
- O_MEM_REQ  out  1  instruction-memory read request
- O_MEM_ADDR  out  PC_W  read address, stable while O_MEM_REQ high
- I_MEM_ACK  in  1  memory returns data this cycle
- I_MEM_DATA  in  16  instruction word, valid with I_MEM_ACK
- O_INST  out  16  fetched instruction to decoder
- O_INST_PC  out  PC_W  address of O_INST
- O_INST_VALID  out  1  O_INST/O_INST_PC valid
- I_INST_READY  in  1  decoder accepts; transfer when VALID & READY at a rising edge
- O_HALTED  out  1  fetch stopped on HALT (see Configuration)

## Operation
- FSM states: IDLE, REQ, HOLD, HALTED (HALTED only with macro).
- IDLE: O_MEM_REQ=0. If I_EN -> REQ next cycle, O_MEM_ADDR=PC.
- REQ: O_MEM_REQ=1, O_MEM_ADDR=PC. Request never withdrawn before I_MEM_ACK, address never changed. On ACK (not squashed): O_INST<=I_MEM_DATA, O_INST_PC<=PC, O_INST_VALID<=1, PC<=PC+1, -> HOLD.
- HOLD: O_INST_VALID=1, outputs stable. On transfer: VALID<=0; -> REQ if I_EN else IDLE.
- PC increment wraps modulo 2^PC_W (max -> 0).
- Branch (I_BR_TAKEN=1), any state: PC<=I_BR_TARGET.
  - IDLE: stays IDLE; next fetch uses target.
  - REQ without ACK same cycle: set squash flag; REQ/ADDR held until ACK; ACK with squash -> data discarded, squash cleared, next cycle REQ at target (I_EN permitting, else IDLE).
  - REQ with ACK same cycle: data discarded, -> REQ at target.
  - HOLD: VALID<=0, held instruction dropped even if READY high same cycle (branch wins), -> REQ at target.
  - HALTED: clears O_HALTED, -> REQ at target.
- I_EN low does not abort an outstanding request or a held instruction; it only blocks new requests.

## Timing
- Reset values: O_MEM_REQ=0, O_MEM_ADDR=RESET_PC, O_INST=0, O_INST_PC=RESET_PC, O_INST_VALID=0, O_HALTED=0, PC=RESET_PC, squash=0, state IDLE.
- Reset mid-request: request dropped immediately; a later ACK while IDLE is ignored.
- All outputs registered. ACK at cycle N -> O_INST_VALID high at N+1.
- Zero-wait memory, READY always high: REQ cycles N, N+2, N+4...; one instruction per 2 cycles.
- Earliest request after reset release with I_EN high: O_MEM_REQ high one cycle later.
- I_MEM_ACK outside REQ ignored.

## Configuration
- IF_HALT_DETECT_EN defined: instruction with opcode I_MEM_DATA[15:11]==OPC_HALT is delivered normally; on its transfer FSM -> HALTED, O_HALTED<=1, no further requests until I_RST or I_BR_TAKEN.
- Not defined: HALT treated as any instruction; HALTED state absent; O_HALTED tied 0.

## Structure
- Shared package risc_pkg: PC_W default, instruction width 16, opcode field position [15:11], OPC_HALT=5'b11111, fetch-state enum.
- Sub-module pc_unit: PC register with reset, load (branch) and increment (wrap) controls.

## Test plan
- Reset, I_EN=1, ACK in the request cycle, READY=1 -> addresses 0,1,2 on O_MEM_ADDR every 2 cycles; O_INST_PC 0,1,2 match fetched data.
- ACK delayed 3 cycles -> O_MEM_REQ held 4 cycles with stable O_MEM_ADDR; VALID exactly one cycle after ACK.
- READY low 5 cycles in HOLD -> O_INST stable, no new request; READY high -> next request following cycle.
- Branch to 0x0040 while REQ to 0x0005 pending, ACK 2 cycles later -> data 0x0005 never valid; next request address 0x0040.
- PC=0xFFFF fetched -> next request address 0x0000.
- With IF_HALT_DETECT_EN: data 0xF800 at addr 3 -> delivered, O_HALTED=1, no request for 10 cycles; branch to 0x0010 -> O_HALTED=0, request 0x0010.
